// File: rtl/flash_cache_pkg.sv
// Shared types and defaults for the flash read cache.
// Pure declarations: no latency, no flow control.
package flash_cache_pkg;

  localparam int FC_LINES  = 16;
  localparam int FC_ADDR_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    GRANT,
    RESP
  } fc_state_t;

endpackage

// File: rtl/flash_cache_store.sv
// Direct-mapped valid/tag/data line store: combinational lookup, one write port.
// Write lands at the clock edge; flush clears every valid bit and overrides a same-cycle write.
module flash_cache_store
  import flash_cache_pkg::*;
#(
  parameter int LINES = FC_LINES,
  parameter int TAG_W = 18,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [31:0]      data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             flush
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign data = data_q[rd_idx];

endmodule

// File: rtl/flash_read_cache.sv
// Read-only word cache in front of spi_flash: hits answer gnt at +1 / rvalid at +2, misses after flash done.
// No backpressure: one request in flight; req_i is ignored until the response has been returned.
module flash_read_cache
  import flash_cache_pkg::*;
#(
  parameter int LINES      = FC_LINES,
  parameter int ADDR_WIDTH = FC_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] flash_addr_o,
  output logic                  flash_strobe_o,
  input  logic [31:0]           flash_rdata_i,
  input  logic                  flash_done_i,
  input  logic                  flash_initialized_i,
  output logic [15:0]           hit_cnt_o,
  output logic [15:0]           miss_cnt_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  fc_state_t             state_q, state_d;
  logic [ADDR_WIDTH-3:0] waddr_q;
  logic [IDX_W-1:0]      idx_q;
  logic [TAG_W-1:0]      tag_q;
  logic [31:0]           rdata_q;
  logic                  strobe_q;
  logic [15:0]           hit_cnt_q;
  logic [15:0]           miss_cnt_q;

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  lk_hit;
  logic [31:0]           lk_data;
  logic                  accept;
  logic                  rd_hit;
  logic                  rd_miss;
  logic                  fill_done;

  assign req_idx   = addr_i[2 +: IDX_W];
  assign req_tag   = addr_i[ADDR_WIDTH-1 : 2+IDX_W];
  assign accept    = (state_q == IDLE) && req_i && flash_initialized_i;
  // A hit coinciding with a flush is treated as a miss, since the line is being invalidated.
  assign rd_hit    = accept && !we_i && lk_hit && !flush_i;
  assign rd_miss   = accept && !we_i && !(lk_hit && !flush_i);
  assign fill_done = (state_q == FILL) && flash_done_i;

  flash_cache_store #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_store (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rd_idx  (req_idx),
    .rd_tag  (req_tag),
    .hit     (lk_hit),
    .data    (lk_data),
    .wr_en   (fill_done),
    .wr_idx  (idx_q),
    .wr_tag  (tag_q),
    .wr_data (flash_rdata_i),
    .flush   (flush_i)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = rd_miss ? FILL : GRANT;
      FILL:    if (flash_done_i) state_d = GRANT;
      GRANT:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      rdata_q    <= '0;
      strobe_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      strobe_q <= rd_miss;
      if (accept) begin
        waddr_q <= addr_i[ADDR_WIDTH-1:2];
        idx_q   <= req_idx;
        tag_q   <= req_tag;
        rdata_q <= rd_hit ? lk_data : 32'h0;
      end
      if (fill_done) begin
        rdata_q <= flash_rdata_i;
      end
      if (rd_hit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (rd_miss && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign gnt_o          = (state_q == GRANT);
  assign rvalid_o       = (state_q == RESP);
  assign rdata_o        = rdata_q;
  assign flash_addr_o   = {waddr_q, 2'b00};
  assign flash_strobe_o = strobe_q;
  assign hit_cnt_o      = hit_cnt_q;
  assign miss_cnt_o     = miss_cnt_q;

endmodule

// File: tb/tb_flash_read_cache.sv
// Directed bench for flash_read_cache with 16 lines and a 24-bit window.
module tb_flash_read_cache;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [23:0] addr_i = '0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        flush_i = 1'b0;
  logic [23:0] flash_addr_o;
  logic        flash_strobe_o;
  logic [31:0] flash_rdata_i = '0;
  logic        flash_done_i = 1'b0;
  logic        flash_initialized_i = 1'b0;
  logic [15:0] hit_cnt_o;
  logic [15:0] miss_cnt_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_hit = '0;
  logic [15:0] exp_miss = '0;

  flash_read_cache #(
    .LINES      (16),
    .ADDR_WIDTH (24)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .req_i               (req_i),
    .we_i                (we_i),
    .addr_i              (addr_i),
    .gnt_o               (gnt_o),
    .rvalid_o            (rvalid_o),
    .rdata_o             (rdata_o),
    .flush_i             (flush_i),
    .flash_addr_o        (flash_addr_o),
    .flash_strobe_o      (flash_strobe_o),
    .flash_rdata_i       (flash_rdata_i),
    .flash_done_i        (flash_done_i),
    .flash_initialized_i (flash_initialized_i),
    .hit_cnt_o           (hit_cnt_o),
    .miss_cnt_o          (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] inc_sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Starts on a negedge; the request is sampled at the following posedge (cycle 0).
  task automatic do_miss(input string tag, input logic [23:0] a, input logic [31:0] d,
                         input int lat, input bit fl_req, input bit fl_done);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; flush_i = fl_req;
    @(negedge clk_i);
    flush_i = 1'b0;
    exp_miss = inc_sat(exp_miss);
    chk({tag, "_strobe"}, {31'b0, flash_strobe_o}, 32'd1);
    chk({tag, "_faddr"}, {8'b0, flash_addr_o}, {8'b0, a[23:2], 2'b00});
    chk({tag, "_gnt_early"}, {31'b0, gnt_o}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk_i);
      chk({tag, "_strobe_pulse"}, {31'b0, flash_strobe_o}, 32'd0);
      chk({tag, "_gnt_wait"}, {31'b0, gnt_o}, 32'd0);
    end
    flash_done_i = 1'b1; flash_rdata_i = d; flush_i = fl_done;
    @(negedge clk_i);
    flash_done_i = 1'b0; flash_rdata_i = '0; flush_i = 1'b0;
    chk({tag, "_gnt"}, {31'b0, gnt_o}, 32'd1);
    chk({tag, "_rvalid_early"}, {31'b0, rvalid_o}, 32'd0);
    req_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_rvalid"}, {31'b0, rvalid_o}, 32'd1);
    chk({tag, "_rdata"}, rdata_o, d);
    chk({tag, "_miss_cnt"}, {16'b0, miss_cnt_o}, {16'b0, exp_miss});
    chk({tag, "_hit_cnt"}, {16'b0, hit_cnt_o}, {16'b0, exp_hit});
    @(negedge clk_i);
  endtask

  task automatic do_hit(input string tag, input logic [23:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    exp_hit = inc_sat(exp_hit);
    chk({tag, "_gnt"}, {31'b0, gnt_o}, 32'd1);
    chk({tag, "_strobe"}, {31'b0, flash_strobe_o}, 32'd0);
    req_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_rvalid"}, {31'b0, rvalid_o}, 32'd1);
    chk({tag, "_rdata"}, rdata_o, d);
    chk({tag, "_hit_cnt"}, {16'b0, hit_cnt_o}, {16'b0, exp_hit});
    chk({tag, "_miss_cnt"}, {16'b0, miss_cnt_o}, {16'b0, exp_miss});
    @(negedge clk_i);
  endtask

  task automatic do_write(input string tag, input logic [23:0] a);
    req_i = 1'b1; we_i = 1'b1; addr_i = a;
    @(negedge clk_i);
    chk({tag, "_gnt"}, {31'b0, gnt_o}, 32'd1);
    chk({tag, "_strobe"}, {31'b0, flash_strobe_o}, 32'd0);
    req_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_rvalid"}, {31'b0, rvalid_o}, 32'd1);
    chk({tag, "_rdata"}, rdata_o, 32'h0);
    chk({tag, "_hit_cnt"}, {16'b0, hit_cnt_o}, {16'b0, exp_hit});
    chk({tag, "_miss_cnt"}, {16'b0, miss_cnt_o}, {16'b0, exp_miss});
    @(negedge clk_i);
  endtask

  initial begin
    // Reset state
    @(negedge clk_i);
    chk("rst_gnt", {31'b0, gnt_o}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst_strobe", {31'b0, flash_strobe_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_faddr", {8'b0, flash_addr_o}, 32'd0);
    chk("rst_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);
    chk("rst_miss_cnt", {16'b0, miss_cnt_o}, 32'd0);
    rst_ni = 1'b1;
    flash_initialized_i = 1'b1;
    @(negedge clk_i);

    do_miss("cold", 24'h200000, 32'hDEADBEEF, 3, 1'b0, 1'b0);
    do_hit("rehit", 24'h200000, 32'hDEADBEEF);

    // Same index, different tag; low address bits ignored
    do_miss("conflict_b", 24'h200041, 32'h11111111, 1, 1'b0, 1'b0);
    do_miss("conflict_a", 24'h200000, 32'h22222222, 2, 1'b0, 1'b0);
    do_hit("conflict_rehit", 24'h200000, 32'h22222222);

    // Writes return zero and leave the cache untouched
    do_write("wr_valid_line", 24'h200000);
    do_hit("post_write_hit", 24'h200000, 32'h22222222);
    do_write("wr_cold_line", 24'h200004);
    do_miss("post_write_miss", 24'h200004, 32'h44444444, 2, 1'b0, 1'b0);

    // Flush on a would-be hit, then flush coinciding with the fill
    do_miss("flush_on_hit", 24'h200000, 32'h66666666, 2, 1'b1, 1'b0);
    do_miss("flush_on_fill", 24'h200008, 32'h55555555, 3, 1'b0, 1'b1);
    do_miss("after_flush", 24'h200008, 32'h77777777, 1, 1'b0, 1'b0);

    // Hit counter saturation, preloaded just below the ceiling
    force dut.hit_cnt_q = 16'hFFFE;
    #1;
    release dut.hit_cnt_q;
    exp_hit = 16'hFFFE;
    do_hit("sat_1", 24'h200008, 32'h77777777);
    do_hit("sat_2", 24'h200008, 32'h77777777);

    // Reset while a fill is outstanding
    req_i = 1'b1; addr_i = 24'h200010;
    @(negedge clk_i);
    chk("rstfill_strobe_before", {31'b0, flash_strobe_o}, 32'd1);
    rst_ni = 1'b0;
    req_i = 1'b0;
    #1;
    exp_hit = '0; exp_miss = '0;
    chk("rstfill_strobe", {31'b0, flash_strobe_o}, 32'd0);
    chk("rstfill_gnt", {31'b0, gnt_o}, 32'd0);
    chk("rstfill_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rstfill_faddr", {8'b0, flash_addr_o}, 32'd0);
    chk("rstfill_rdata", rdata_o, 32'd0);
    chk("rstfill_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);
    chk("rstfill_miss_cnt", {16'b0, miss_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    flash_done_i = 1'b1; flash_rdata_i = 32'hBAD0BAD0;
    @(negedge clk_i);
    flash_done_i = 1'b0; flash_rdata_i = '0;
    chk("stale_done_gnt", {31'b0, gnt_o}, 32'd0);
    @(negedge clk_i);
    chk("stale_done_gnt2", {31'b0, gnt_o}, 32'd0);
    chk("stale_done_rvalid", {31'b0, rvalid_o}, 32'd0);

    // Request held while the flash controller is not ready
    flash_initialized_i = 1'b0;
    req_i = 1'b1; addr_i = 24'h200000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("uninit_gnt", {31'b0, gnt_o}, 32'd0);
      chk("uninit_strobe", {31'b0, flash_strobe_o}, 32'd0);
    end
    flash_initialized_i = 1'b1;
    do_miss("init_rise", 24'h200000, 32'hCAFEF00D, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
